// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings and the arbiter FSM state type shared by the ALU arbiter slice.
package alu_pkg;
  localparam logic [4:0] ALU_OP_ADD  = 5'b00000;
  localparam logic [4:0] ALU_OP_SLL  = 5'b00001;
  localparam logic [4:0] ALU_OP_SLT  = 5'b00010;
  localparam logic [4:0] ALU_OP_SLTU = 5'b00011;
  localparam logic [4:0] ALU_OP_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OP_SRL  = 5'b00101;
  localparam logic [4:0] ALU_OP_OR   = 5'b00110;
  localparam logic [4:0] ALU_OP_AND  = 5'b00111;
  localparam logic [4:0] ALU_OP_SUB  = 5'b01000;
  localparam logic [4:0] ALU_OP_SRA  = 5'b01101;
  localparam logic [4:0] ALU_OP_BEQ  = 5'b10000;
  localparam logic [4:0] ALU_OP_BNE  = 5'b10001;
  localparam logic [4:0] ALU_OP_BLT  = 5'b10100;
  localparam logic [4:0] ALU_OP_BGE  = 5'b10101;
  localparam logic [4:0] ALU_OP_BLTU = 5'b10110;
  localparam logic [4:0] ALU_OP_BGEU = 5'b10111;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way one-hot grant, round-robin on ties or port 0 first when PRIO_FIXED.
// Ports: clk, reset_n (sync, active-low), req[1:0] request vector, en allows granting,
// gnt[1:0] one-hot combinational grant. last_q remembers the last granted port (resets to 1).
module rr_arbiter2 #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_q, last_d, pick1;
  always_comb begin
    pick1 = req[1] & (~req[0] | (~PRIO_FIXED & ~last_q));
    gnt = en ? {pick1, req[0] & ~pick1} : 2'b00;
    last_d = |gnt ? gnt[1] : last_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between the execute stage (port 0) and branch unit (port 1).
// Ports: clk, reset_n (sync, active-low); reqN_valid/ready/op/a/b request channels;
// rspN_valid/ready/result/fault response channels; alu_available/op/in_a/in_b drive the ALU,
// alu_out/alu_fault are its registered outputs, valid the cycle after the strobe.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output logic        rsp0_fault,
  output logic        rsp1_fault,
  output logic        alu_available,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_in_a,
  output logic [31:0] alu_in_b,
  input  logic [31:0] alu_out,
  input  logic        alu_fault
);
  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic [31:0] res0_q, res0_d, res1_q, res1_d;
  logic        flt0_q, flt0_d, flt1_q, flt1_d;
  logic [1:0]  gnt;
  logic        cap0, cap1;
  // Grants only from IDLE and never while reset is held.
  rr_arbiter2 #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    ({req1_valid, req0_valid}),
    .en     (state_q == IDLE && reset_n),
    .gnt    (gnt)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
      flt0_q  <= 1'b0;
      flt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      flt0_q  <= flt0_d;
      flt1_q  <= flt1_d;
    end
  end
  // ALU fault is only valid in WAIT, so the capture happens there and nowhere else.
  always_comb begin
    cap0 = state_q == WAIT && !win_q;
    cap1 = state_q == WAIT && win_q;
    state_d = state_q == IDLE ? (|gnt ? WAIT : IDLE) :
              state_q == WAIT ? RESP :
              (win_q ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
    win_d  = |gnt ? gnt[1] : win_q;
    res0_d = cap0 ? alu_out : res0_q;
    flt0_d = cap0 ? alu_fault : flt0_q;
    res1_d = cap1 ? alu_out : res1_q;
    flt1_d = cap1 ? alu_fault : flt1_q;
  end
  always_comb begin
    req0_ready    = gnt[0];
    req1_ready    = gnt[1];
    alu_available = |gnt;
    alu_op        = gnt[1] ? req1_op : gnt[0] ? req0_op : '0;
    alu_in_a      = gnt[1] ? req1_a : gnt[0] ? req0_a : '0;
    alu_in_b      = gnt[1] ? req1_b : gnt[0] ? req0_b : '0;
    rsp0_valid    = state_q == RESP && !win_q;
    rsp1_valid    = state_q == RESP && win_q;
    rsp0_result   = res0_q;
    rsp1_result   = res1_q;
    rsp0_fault    = flt0_q;
    rsp1_fault    = flt1_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a registered ALU model.
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] rv = '0, sr = 2'b11, rr, sv, sflt;
  logic [4:0] rop[2];
  logic [31:0] ra[2], rb[2], sres[2];
  logic alu_av, alu_flt;
  logic [4:0] alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0] f_rv = '0, f_sr = 2'b11, f_rr, f_sv, f_sflt;
  logic [4:0] f_op[2];
  logic [31:0] f_a[2], f_b[2], f_sres[2];
  logic f_av, f_flt;
  logic [4:0] f_aop;
  logic [31:0] f_ia, f_ib, f_out;
  int vecs = 0, errs = 0, cyc = 0;
  int gcyc[2];
  logic [1:0] pv = '0;
  logic [32:0] e0[$], e1[$];
  int eg[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(rv[0]), .req1_valid(rv[1]), .req0_ready(rr[0]), .req1_ready(rr[1]),
    .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]),
    .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]),
    .rsp0_valid(sv[0]), .rsp1_valid(sv[1]), .rsp0_ready(sr[0]), .rsp1_ready(sr[1]),
    .rsp0_result(sres[0]), .rsp1_result(sres[1]), .rsp0_fault(sflt[0]), .rsp1_fault(sflt[1]),
    .alu_available(alu_av), .alu_op(alu_op), .alu_in_a(alu_a), .alu_in_b(alu_b),
    .alu_out(alu_out), .alu_fault(alu_flt)
  );

  alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fix (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(f_rv[0]), .req1_valid(f_rv[1]), .req0_ready(f_rr[0]), .req1_ready(f_rr[1]),
    .req0_op(f_op[0]), .req0_a(f_a[0]), .req0_b(f_b[0]),
    .req1_op(f_op[1]), .req1_a(f_a[1]), .req1_b(f_b[1]),
    .rsp0_valid(f_sv[0]), .rsp1_valid(f_sv[1]), .rsp0_ready(f_sr[0]), .rsp1_ready(f_sr[1]),
    .rsp0_result(f_sres[0]), .rsp1_result(f_sres[1]), .rsp0_fault(f_sflt[0]), .rsp1_fault(f_sflt[1]),
    .alu_available(f_av), .alu_op(f_aop), .alu_in_a(f_ia), .alu_in_b(f_ib),
    .alu_out(f_out), .alu_fault(f_flt)
  );

  function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_OP_ADD:  return {1'b0, a + b};
      ALU_OP_SLL:  return {1'b0, a << b[4:0]};
      ALU_OP_SLT:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
      ALU_OP_SLTU: return {1'b0, 31'd0, a < b};
      ALU_OP_XOR:  return {1'b0, a ^ b};
      ALU_OP_SRL:  return {1'b0, a >> b[4:0]};
      ALU_OP_OR:   return {1'b0, a | b};
      ALU_OP_AND:  return {1'b0, a & b};
      ALU_OP_SUB:  return {1'b0, a - b};
      ALU_OP_SRA:  return {1'b0, $signed(a) >>> b[4:0]};
      ALU_OP_BEQ:  return {1'b0, 31'd0, a == b};
      ALU_OP_BNE:  return {1'b0, 31'd0, a != b};
      ALU_OP_BLT:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
      ALU_OP_BGE:  return {1'b0, 31'd0, $signed(a) >= $signed(b)};
      ALU_OP_BLTU: return {1'b0, 31'd0, a < b};
      ALU_OP_BGEU: return {1'b0, 31'd0, a >= b};
      default:     return {1'b1, 32'd0};
    endcase
  endfunction

  // Registered ALU models: result latched on the strobe, fault cleared the cycle after.
  always @(posedge clk) begin
    if (!reset_n) {alu_flt, alu_out} <= '0;
    else {alu_flt, alu_out} <= alu_av ? alu_f(alu_op, alu_a, alu_b) : {1'b0, alu_out};
    if (!reset_n) {f_flt, f_out} <= '0;
    else {f_flt, f_out} <= f_av ? alu_f(f_aop, f_ia, f_ib) : {1'b0, f_out};
  end

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: grant order, accept-to-valid latency and response payloads.
  always @(negedge clk) begin
    #2;
    if (|rr) chk("grant onehot", 33'($countones(rr)), 33'd1);
    for (int p = 0; p < 2; p++) begin
      if (rr[p]) begin
        gcyc[p] = cyc;
        if (eg.size() == 0) bad($sformatf("unexpected grant port %0d", p));
        else chk("grant port", 33'(p), 33'(eg.pop_front()));
      end
      if (sv[p] && !pv[p]) begin
        if ((p == 0 ? e0.size() : e1.size()) == 0) bad($sformatf("unexpected rsp%0d_valid", p));
        else chk($sformatf("rsp%0d latency", p), 33'(cyc - gcyc[p]), 33'd2);
      end
      if (sv[p] && sr[p]) begin
        if (p == 0 && e0.size() != 0) chk("rsp0 fault,result", {sflt[0], sres[0]}, e0.pop_front());
        if (p == 1 && e1.size() != 0) chk("rsp1 fault,result", {sflt[1], sres[1]}, e1.pop_front());
      end
      pv[p] = sv[p];
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance with valid dropped.
  task automatic drive(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    rv[p] = 1'b1;
    rop[p] = op;
    ra[p] = a;
    rb[p] = b;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (rr[p]) begin
        @(negedge clk);
        rv[p] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    rv[p] = 1'b0;
    bad($sformatf("req%0d accept timeout", p));
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (e0.size() == 0 && e1.size() == 0 && eg.size() == 0) begin
        @(negedge clk);
        return;
      end
    end
    bad("drain timeout");
    e0.delete();
    e1.delete();
    eg.delete();
    @(negedge clk);
  endtask

  initial begin
    int n0, n1;
    for (int p = 0; p < 2; p++) begin
      rop[p] = ALU_OP_XOR; ra[p] = 32'h55; rb[p] = 32'h0f;
      f_op[p] = p == 0 ? ALU_OP_ADD : ALU_OP_SUB; f_a[p] = 32'd2; f_b[p] = 32'd3;
    end
    rv = 2'b11;
    repeat (3) @(negedge clk);
    #3;
    chk("reset req_ready", {31'd0, rr}, 33'd0);
    chk("reset alu_available", {32'd0, alu_av}, 33'd0);
    chk("reset alu_op", {28'd0, alu_op}, 33'd0);
    chk("reset alu_in_a", {1'b0, alu_a}, 33'd0);
    chk("reset rsp_valid", {31'd0, sv}, 33'd0);
    chk("reset rsp0", {sflt[0], sres[0]}, 33'd0);
    chk("reset rsp1", {sflt[1], sres[1]}, 33'd0);
    rv = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Tie after reset: port 0 first.
    eg.push_back(0); eg.push_back(1);
    e0.push_back({1'b0, 32'd7}); e1.push_back({1'b0, 32'd16});
    fork
      drive(0, ALU_OP_SUB, 32'd10, 32'd3);
      drive(1, ALU_OP_SLL, 32'd1, 32'd4);
    join
    drain();

    // Single request on port 0.
    eg.push_back(0); e0.push_back({1'b0, 32'd12});
    drive(0, ALU_OP_ADD, 32'd5, 32'd7);
    drain();

    // Invalid op faults, following valid op on the same port is clean.
    eg.push_back(1); e1.push_back({1'b1, 32'd0});
    drive(1, 5'b01010, 32'd3, 32'd4);
    drain();
    eg.push_back(1); e1.push_back({1'b0, 32'd7});
    drive(1, ALU_OP_ADD, 32'd3, 32'd4);
    drain();

    // Backpressure on rsp0 with req1 waiting.
    sr[0] = 1'b0;
    eg.push_back(0); eg.push_back(1);
    e0.push_back({1'b0, 32'h0f}); e1.push_back({1'b0, 32'd8});
    fork
      drive(0, ALU_OP_XOR, 32'hf0, 32'hff);
      drive(1, ALU_OP_AND, 32'hc, 32'ha);
      begin
        for (int i = 0; i < 20 && !sv[0]; i++) begin
          @(negedge clk);
          #3;
        end
        for (int k = 0; k < 5; k++) begin
          chk("stall rsp0_valid", {32'd0, sv[0]}, 33'd1);
          chk("stall rsp0 fault,result", {sflt[0], sres[0]}, {1'b0, 32'h0f});
          chk("stall req1_ready", {32'd0, rr[1]}, 33'd0);
          @(negedge clk);
          #3;
        end
        @(negedge clk);
        #1 sr[0] = 1'b1;
        @(negedge clk);
        #3 chk("req1 granted after handshake", {32'd0, rr[1]}, 33'd1);
      end
    join
    drain();

    // Reset during WAIT discards the operation.
    eg.push_back(0);
    drive(0, ALU_OP_ADD, 32'd1, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    #3;
    chk("midreset rsp_valid", {31'd0, sv}, 33'd0);
    chk("midreset rsp0", {sflt[0], sres[0]}, 33'd0);
    chk("midreset alu_available", {32'd0, alu_av}, 33'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    eg.push_back(0); eg.push_back(1);
    e0.push_back({1'b0, 32'd4}); e1.push_back({1'b0, 32'd6});
    fork
      drive(0, ALU_OP_ADD, 32'd2, 32'd2);
      drive(1, ALU_OP_ADD, 32'd3, 32'd3);
    join
    drain();

    // Fairness: alternating grants under continuous requests.
    for (int k = 0; k < 3; k++) begin
      eg.push_back(0); eg.push_back(1);
      e0.push_back({1'b0, 32'hf}); e1.push_back({1'b0, 32'hf8000000});
    end
    fork
      repeat (3) drive(0, ALU_OP_OR, 32'h5, 32'ha);
      repeat (3) drive(1, ALU_OP_SRA, 32'h80000000, 32'd4);
    join
    drain();

    // Fixed priority: port 0 takes every grant.
    n0 = 0;
    n1 = 0;
    f_rv = 2'b11;
    for (int i = 0; i < 60 && n0 + n1 < 6; i++) begin
      @(negedge clk);
      #3;
      if (f_rr[0]) n0++;
      if (f_rr[1]) n1++;
      if (f_sv[0]) chk("fixed rsp0 fault,result", {f_sflt[0], f_sres[0]}, {1'b0, 32'd5});
    end
    @(negedge clk);
    f_rv = 2'b00;
    chk("fixed port0 grants", 33'(n0), 33'd6);
    chk("fixed port1 grants", 33'(n1), 33'd0);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
